// File: rtl/id_stage_piped.sv
// RV32I decode stage: decode, register-file read with WB write-through, registered ID/EX boundary.
// One cycle latency. Load-use stall and flush load a bubble; flush outranks stall.
module id_stage_piped #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic                 flush,
  input  logic                 reg_write,
  input  logic [REG_SEL-1:0]   rd_select,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 stall,
  output logic                 out_valid,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] immd,
  output logic [WORD_SIZE-1:0] data1,
  output logic [WORD_SIZE-1:0] data2,
  output logic [REG_SEL-1:0]   rs1,
  output logic [REG_SEL-1:0]   rs2,
  output logic [REG_SEL-1:0]   destination,
  output logic [3:0]           alu_op,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_write_out,
  output logic                 alu_src,
  output logic                 branch,
  output logic                 jump,
  output logic                 pc_src1,
  output logic                 illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] immd;
    logic [WORD_SIZE-1:0] data1;
    logic [WORD_SIZE-1:0] data2;
    logic [REG_SEL-1:0]   rs1;
    logic [REG_SEL-1:0]   rs2;
    logic [REG_SEL-1:0]   dest;
    logic [3:0]           alu_op;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 alu_src;
    logic                 branch;
    logic                 jump;
    logic                 pc_src1;
    logic                 illegal;
  } id_ex_t;

  logic [WORD_SIZE-1:0] rf_q [NUM_REGS];
  logic [WORD_SIZE-1:0] rf_d [NUM_REGS];
  id_ex_t               ex_q, ex_d, dec;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [REG_SEL-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [31:0]          imm32;
  logic [WORD_SIZE-1:0] rdata1, rdata2;
  logic                 use_rs1, use_rs2;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[15 +: REG_SEL];
  assign rs2_idx = instr[20 +: REG_SEL];
  assign rd_idx  = instr[7 +: REG_SEL];

  // Write-through read: a same-cycle WB write to the source index wins over stored state.
  function automatic logic [WORD_SIZE-1:0] rf_read(input logic [REG_SEL-1:0] idx);
    if (idx == '0)
      return '0;
    else if (reg_write && rd_select == idx)
      return rd_data;
    else
      return rf_q[idx];
  endfunction

  assign rdata1 = rf_read(rs1_idx);
  assign rdata2 = rf_read(rs2_idx);

  always_comb begin
    rf_d = rf_q;
    if (reg_write && rd_select != '0)
      rf_d[rd_select] = rd_data;
  end

  always_comb begin
    dec    = '0;
    imm32  = '0;
    dec.valid = 1'b1;
    dec.pc    = pc;
    dec.rs1   = rs1_idx;
    dec.rs2   = rs2_idx;
    dec.dest  = rd_idx;
    dec.data1 = rdata1;
    dec.data2 = rdata2;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = {instr[30], funct3};
      end
      OPC_OP_IMM: begin
        imm32         = {{20{instr[31]}}, instr[31:20]};
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = {(funct3 == 3'b101) & instr[30], funct3};
      end
      OPC_LOAD: begin
        imm32          = {{20{instr[31]}}, instr[31:20]};
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        imm32         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.branch = 1'b1;
        dec.alu_op = 4'b1000;
      end
      OPC_JAL: begin
        imm32         = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.pc_src1   = 1'b1;
      end
      OPC_JALR: begin
        imm32         = {{20{instr[31]}}, instr[31:20]};
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OPC_LUI: begin
        imm32         = {instr[31:12], 12'b0};
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OPC_AUIPC: begin
        imm32         = {instr[31:12], 12'b0};
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.pc_src1   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.immd = WORD_SIZE'($signed(imm32));
    // PC-relative and upper-immediate forms take no register operands.
    if (opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL) begin
      dec.data1 = '0;
      dec.data2 = '0;
    end
  end

  always_comb begin
    use_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
              (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
    use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    stall   = !rst && !flush && in_valid && ex_q.valid && ex_q.mem_read &&
              (ex_q.dest != '0) &&
              ((use_rs1 && rs1_idx == ex_q.dest) || (use_rs2 && rs2_idx == ex_q.dest));
  end

  always_comb begin
    ex_d = dec;
    if (flush || !in_valid || stall)
      ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[i] <= '0;
    end else begin
      ex_q <= ex_d;
      rf_q <= rf_d;
    end
  end

  assign out_valid     = ex_q.valid;
  assign out_pc        = ex_q.pc;
  assign immd          = ex_q.immd;
  assign data1         = ex_q.data1;
  assign data2         = ex_q.data2;
  assign rs1           = ex_q.rs1;
  assign rs2           = ex_q.rs2;
  assign destination   = ex_q.dest;
  assign alu_op        = ex_q.alu_op;
  assign mem_read      = ex_q.mem_read;
  assign mem_write     = ex_q.mem_write;
  assign mem_to_reg    = ex_q.mem_to_reg;
  assign reg_write_out = ex_q.reg_write;
  assign alu_src       = ex_q.alu_src;
  assign branch        = ex_q.branch;
  assign jump          = ex_q.jump;
  assign pc_src1       = ex_q.pc_src1;
  assign illegal       = ex_q.illegal;

endmodule
